motoro3_seq: RTL and testbench
==============================

MOTORO3_SEQ -- requirements
Module: motoro3_seq

Interface
REQ-001 SHALL have parameter RAMP_DIV, default 10000: clkI cycles per speed step (1 ms at 10 MHz).
REQ-002 SHALL have parameter DWELL_CYC, default 50000: zero-speed dwell before a direction flip.
REQ-003 SHALL have parameter SPD_MAX, default 15: highest speed step accepted.
REQ-004 SHALL have port clkI  in  1  single clock, 10 MHz; all logic on its rising edge.
REQ-005 SHALL have port nRstI  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cmdRunI  in  1  level; 1 = motor requested running.
REQ-007 SHALL have port cmdDirI  in  1  level; requested direction, 1 = inverse rotation.
REQ-008 SHALL have port cmdSpeedI  in  4  target speed step; values above SPD_MAX clamp to SPD_MAX.
REQ-009 SHALL have port faultI  in  1  level; 1 = immediate force stop.
REQ-010 SHALL have port m3startO  out  1  level run-enable to the motor top.
REQ-011 SHALL have port m3forceStopO  out  1  level force stop to the motor top.
REQ-012 SHALL have port m3invRotateO  out  1  level direction to the motor top.
REQ-013 SHALL have port m3freqINCo  out  1  one-cycle pulse, frequency up one step.
REQ-014 SHALL have port m3freqDECo  out  1  one-cycle pulse, frequency down one step.
REQ-015 SHALL have port speedNowO  out  4  current speed step (count of net INC pulses).
REQ-016 SHALL have port stateO  out  3  current FSM state code.

Function
REQ-017 SHALL implement states IDLE, START, RAMP, RUN, DECEL, DWELL, FAULT.
REQ-018 SHALL restart the tick counter at 0 on every state entry; a tick fires once the counter reaches RAMP_DIV-1, then the counter reloads to 0.
REQ-019 SHALL drive all outputs from registers; command inputs are sampled once and then acted on the next edge (1-cycle latency).
REQ-020 IDLE: m3startO=0; when cmdRunI=1 and faultI=0, load m3invRotateO<=cmdDirI and go to START.
REQ-021 START: m3startO=1; on the first tick go to RAMP.
REQ-022 RAMP: on each tick, pulse INC and increment speedNowO if speedNowO < target, or pulse DEC and decrement if speedNowO > target; when speedNowO = target go to RUN with no pulse.
REQ-023 RUN: hold speed; go to RAMP on a target change; go to DECEL on cmdRunI=0 or on cmdDirI != m3invRotateO.
REQ-024 DECEL: on each tick, pulse DEC and decrement until speedNowO = 0.
REQ-025 DECEL exit at speed 0: if cmdRunI=0, clear m3startO and go to IDLE; otherwise go to DWELL.
REQ-026 DWELL: m3startO=0 for DWELL_CYC cycles, then set m3invRotateO<=cmdDirI and go to START.
REQ-027 SHALL never assert m3freqINCo and m3freqDECo in the same cycle, and never pulse INC at SPD_MAX or DEC at 0.
REQ-028 SHALL change m3invRotateO only in IDLE or at DWELL exit, never while speedNowO != 0.
REQ-029 faultI=1 SHALL have priority from any state: next cycle go to FAULT, m3forceStopO=1, m3startO=0, speedNowO=0, no pulse, even if a tick coincides.
REQ-030 FAULT SHALL go to IDLE only when faultI=0 and cmdRunI=0 are sampled in the same cycle.
REQ-031 cmdRunI dropping during RAMP or START SHALL go directly to DECEL.
REQ-032 A target of 0 with cmdRunI=1 SHALL ramp to 0 and stay in RUN with m3startO=1.

Reset
REQ-033 On nRstI low, SHALL go to IDLE and clear every output to 0 (including m3invRotateO, m3forceStopO and speedNowO) and clear both counters, at any point in operation.
REQ-034 After reset release, SHALL act on no command before the first rising edge of clkI.

Structure
REQ-035 State codes (IDLE=0, START=1, RAMP=2, RUN=3, DECEL=4, DWELL=5, FAULT=6) and SPD width SHALL live in the shared motoro3 package/include.
REQ-036 The tick/dwell counter SHALL be one sub-module, motoro3_tick (restart input, terminal count input, tick output).

Verification (RAMP_DIV=4, DWELL_CYC=8)
REQ-037 Reset, then cmdRunI=1, cmdSpeedI=3 -> START, then 3 INC pulses 4 cycles apart, speedNowO=3, state RUN.
REQ-038 In RUN at speed 3, cmdDirI toggled -> 3 DEC pulses, m3startO=0 for 8 cycles, m3invRotateO flips, then 3 INC pulses.
REQ-039 faultI=1 mid-ramp on a tick cycle -> no pulse, FAULT, m3forceStopO=1, speedNowO=0; release requires faultI=0 and cmdRunI=0.
REQ-040 cmdSpeedI=15 then 9 in RUN -> reach 15, then exactly 6 DEC pulses; INC and DEC never asserted together.
REQ-041 nRstI pulsed low at speed 5 -> all outputs 0 asynchronously, state IDLE.

Source files
------------

// File: rtl/motoro3_pkg.sv
// Shared definitions for the motoro3 sequencer: state codes and speed width.
package motoro3_pkg;

    localparam int SPD_W = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        RAMP  = 3'd2,
        RUN   = 3'd3,
        DECEL = 3'd4,
        DWELL = 3'd5,
        FAULT = 3'd6
    } stateT;

endpackage

// File: rtl/motoro3_tick.sv
// Free-running terminal counter. The restart input zeroes the count for the
// current cycle, so the first cycle of a restart already counts as cycle 0.
module motoro3_tick #(
    parameter int CNT_W = 16
) (
    input  logic             clkI,
    input  logic             nRstI,
    input  logic             restartI,
    input  logic [CNT_W-1:0] termI,
    output logic             tickO
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntEff;

    assign cntEff = restartI ? '0 : cnt;
    assign tickO  = (cntEff == termI);

    // Count up to the terminal value, then reload to 0.
    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            cnt <= '0;
        end else if (tickO) begin
            cnt <= '0;
        end else begin
            cnt <= cntEff + 1'b1;
        end
    end

endmodule

// File: rtl/motoro3_seq.sv
// motoro3_seq: run / direction / speed-ramp sequencer for the motoro3 motor
// top. Commands are registered once, then acted on by the FSM one edge later.
module motoro3_seq
    import motoro3_pkg::*;
#(
    parameter int RAMP_DIV  = 10000,
    parameter int DWELL_CYC = 50000,
    parameter int SPD_MAX   = 15
) (
    input  logic             clkI,
    input  logic             nRstI,
    input  logic             cmdRunI,
    input  logic             cmdDirI,
    input  logic [SPD_W-1:0] cmdSpeedI,
    input  logic             faultI,
    output logic             m3startO,
    output logic             m3forceStopO,
    output logic             m3invRotateO,
    output logic             m3freqINCo,
    output logic             m3freqDECo,
    output logic [SPD_W-1:0] speedNowO,
    output logic [2:0]       stateO
);

    localparam int CNT_MAX = (RAMP_DIV > DWELL_CYC) ? RAMP_DIV : DWELL_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] RAMP_TERM  = CNT_W'(RAMP_DIV - 1);
    localparam logic [CNT_W-1:0] DWELL_TERM = CNT_W'(DWELL_CYC - 1);
    localparam logic [SPD_W:0]   SPD_LIM    = (SPD_W + 1)'(SPD_MAX);

    // Saturate a requested speed step to SPD_MAX (compared one bit wider so
    // the test stays meaningful when SPD_MAX is the full 4-bit range).
    function automatic logic [SPD_W-1:0] clampSpd(input logic [SPD_W-1:0] req);
        logic [SPD_W:0] reqW;
        reqW = {1'b0, req};
        if (reqW > SPD_LIM) begin
            clampSpd = SPD_LIM[SPD_W-1:0];
        end else begin
            clampSpd = req;
        end
    endfunction

    logic             runQ, dirQ, faultQ;
    logic [SPD_W-1:0] tgtQ;
    stateT            stateQ;
    logic             startQ, fstopQ, invQ, incQ, decQ, entryQ;
    logic [SPD_W-1:0] speedQ;
    logic             rampTick, dwellTick;

    // Both counters restart on the first cycle of every state.
    motoro3_tick #(.CNT_W(CNT_W)) rampTickU (
        .clkI    (clkI),
        .nRstI   (nRstI),
        .restartI(entryQ),
        .termI   (RAMP_TERM),
        .tickO   (rampTick)
    );

    motoro3_tick #(.CNT_W(CNT_W)) dwellTickU (
        .clkI    (clkI),
        .nRstI   (nRstI),
        .restartI(entryQ),
        .termI   (DWELL_TERM),
        .tickO   (dwellTick)
    );

    // Sample the command inputs once; the FSM only ever sees these copies.
    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            runQ   <= 1'b0;
            dirQ   <= 1'b0;
            faultQ <= 1'b0;
            tgtQ   <= '0;
        end else begin
            runQ   <= cmdRunI;
            dirQ   <= cmdDirI;
            faultQ <= faultI;
            tgtQ   <= clampSpd(cmdSpeedI);
        end
    end

    // Sequencer FSM with registered outputs; a sampled fault overrides all.
    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            stateQ <= IDLE;
            startQ <= 1'b0;
            fstopQ <= 1'b0;
            invQ   <= 1'b0;
            incQ   <= 1'b0;
            decQ   <= 1'b0;
            speedQ <= '0;
            entryQ <= 1'b0;
        end else begin
            incQ   <= 1'b0;
            decQ   <= 1'b0;
            entryQ <= 1'b0;
            if (faultQ) begin
                stateQ <= FAULT;
                entryQ <= (stateQ != FAULT);
                fstopQ <= 1'b1;
                startQ <= 1'b0;
                speedQ <= '0;
            end else begin
                case (stateQ)
                    IDLE: begin
                        if (runQ) begin
                            invQ   <= dirQ;
                            startQ <= 1'b1;
                            stateQ <= START;
                            entryQ <= 1'b1;
                        end
                    end
                    START: begin
                        if (!runQ) begin
                            stateQ <= DECEL;
                            entryQ <= 1'b1;
                        end else if (rampTick) begin
                            stateQ <= RAMP;
                            entryQ <= 1'b1;
                        end
                    end
                    RAMP: begin
                        if (!runQ) begin
                            stateQ <= DECEL;
                            entryQ <= 1'b1;
                        end else if (speedQ == tgtQ) begin
                            stateQ <= RUN;
                            entryQ <= 1'b1;
                        end else if (rampTick) begin
                            if (speedQ < tgtQ) begin
                                incQ   <= 1'b1;
                                speedQ <= speedQ + 1'b1;
                            end else begin
                                decQ   <= 1'b1;
                                speedQ <= speedQ - 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (!runQ || (dirQ != invQ)) begin
                            stateQ <= DECEL;
                            entryQ <= 1'b1;
                        end else if (speedQ != tgtQ) begin
                            stateQ <= RAMP;
                            entryQ <= 1'b1;
                        end
                    end
                    DECEL: begin
                        if (speedQ == '0) begin
                            startQ <= 1'b0;
                            stateQ <= runQ ? DWELL : IDLE;
                            entryQ <= 1'b1;
                        end else if (rampTick) begin
                            decQ   <= 1'b1;
                            speedQ <= speedQ - 1'b1;
                        end
                    end
                    DWELL: begin
                        if (dwellTick) begin
                            invQ   <= dirQ;
                            startQ <= 1'b1;
                            stateQ <= START;
                            entryQ <= 1'b1;
                        end
                    end
                    FAULT: begin
                        if (!runQ) begin
                            fstopQ <= 1'b0;
                            stateQ <= IDLE;
                            entryQ <= 1'b1;
                        end
                    end
                    default: begin
                        startQ <= 1'b0;
                        stateQ <= IDLE;
                        entryQ <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign m3startO     = startQ;
    assign m3forceStopO = fstopQ;
    assign m3invRotateO = invQ;
    assign m3freqINCo   = incQ;
    assign m3freqDECo   = decQ;
    assign speedNowO    = speedQ;
    assign stateO       = stateQ;

endmodule

// File: tb/tb_motoro3_seq.sv
// Bench for motoro3_seq: directed sequences, a scenario table, and random
// command streams checked against rule-level expectations.
`timescale 1ns/1ps
module tb_motoro3_seq;

    localparam int RAMP_DIV  = 4;
    localparam int DWELL_CYC = 8;
    localparam int SPD_MAX   = 15;
    localparam int S_IDLE = 0, S_START = 1, S_RAMP = 2, S_RUN = 3, S_FAULT = 6;

    logic       clkI = 1'b0;
    logic       nRstI = 1'b1;
    logic       cmdRunI = 1'b0, cmdDirI = 1'b0, faultI = 1'b0;
    logic [3:0] cmdSpeedI = 4'd0;
    logic       m3startO, m3forceStopO, m3invRotateO, m3freqINCo, m3freqDECo;
    logic [3:0] speedNowO;
    logic [2:0] stateO;

    int nChecks = 0;
    int nFail   = 0;

    motoro3_seq #(.RAMP_DIV(RAMP_DIV), .DWELL_CYC(DWELL_CYC), .SPD_MAX(SPD_MAX)) dut (
        .clkI(clkI), .nRstI(nRstI), .cmdRunI(cmdRunI), .cmdDirI(cmdDirI),
        .cmdSpeedI(cmdSpeedI), .faultI(faultI), .m3startO(m3startO),
        .m3forceStopO(m3forceStopO), .m3invRotateO(m3invRotateO),
        .m3freqINCo(m3freqINCo), .m3freqDECo(m3freqDECo),
        .speedNowO(speedNowO), .stateO(stateO)
    );

    always #50 clkI = ~clkI;

    task automatic chk(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clkI);
        #1;
    endtask

    task automatic setCmd(input logic run, input logic dir, input logic [3:0] spd, input logic flt);
        cmdRunI = run; cmdDirI = dir; cmdSpeedI = spd; faultI = flt;
    endtask

    task automatic chkOut(input string tag, input int st, input int spd, input int start, input int inv, input int fs);
        chk({tag, "_state"}, int'(stateO), st);
        chk({tag, "_speed"}, int'(speedNowO), spd);
        chk({tag, "_start"}, int'(m3startO), start);
        if (inv >= 0) chk({tag, "_inv"}, int'(m3invRotateO), inv);
        chk({tag, "_fstop"}, int'(m3forceStopO), fs);
    endtask

    // Rule monitor: speed equals net pulse count, pulses exclusive, bounded,
    // spaced by at least one ramp period, direction only changes at rest.
    bit   monOn = 1'b0;
    int   mSpd = 0, negCyc = 0, lastPulse = -100;
    logic mInv = 1'b0;
    always @(negedge clkI) begin
        negCyc++;
        if (!nRstI) begin
            mSpd = 0; mInv = 1'b0; lastPulse = -100;
        end else if (monOn) begin
            chk("mon_inc_dec_exclusive", int'(m3freqINCo & m3freqDECo), 0);
            if (m3freqINCo) begin
                chk("mon_inc_below_max", int'(mSpd < SPD_MAX), 1);
                mSpd++;
            end
            if (m3freqDECo) begin
                chk("mon_dec_above_zero", int'(mSpd > 0), 1);
                mSpd--;
            end
            if (m3freqINCo | m3freqDECo) begin
                chk("mon_pulse_spacing", int'((negCyc - lastPulse) >= RAMP_DIV), 1);
                lastPulse = negCyc;
            end
            if (m3forceStopO) begin
                mSpd = 0;
                chk("mon_fault_start_low", int'(m3startO), 0);
            end
            chk("mon_speed_net_pulses", int'(speedNowO), mSpd);
            if (m3invRotateO != mInv) chk("mon_dir_change_at_rest", int'(speedNowO), 0);
            mInv = m3invRotateO;
        end
    end

    typedef struct {
        logic       run;
        logic       dir;
        logic [3:0] spd;
        logic       flt;
        int         hold;
        int         eState;
        int         eSpd;
        int         eStart;
        int         eInv;
        int         eFs;
    } vecT;

    vecT tbl[11];

    initial begin
        int firstInc, incN, decN, startLow, incBeforeFlip, lastInc, gapBad;
        logic flipped, lat, rRun, rDir, rFlt;
        logic [3:0] rSpd;

        tbl[0]  = '{1'b1, 1'b0, 4'd3,  1'b0, 30, S_RUN,   3,  1, 0, 0};
        tbl[1]  = '{1'b1, 1'b1, 4'd3,  1'b0, 60, S_RUN,   3,  1, 1, 0};
        tbl[2]  = '{1'b1, 1'b1, 4'd0,  1'b0, 30, S_RUN,   0,  1, 1, 0};
        tbl[3]  = '{1'b1, 1'b1, 4'd7,  1'b0, 50, S_RUN,   7,  1, 1, 0};
        tbl[4]  = '{1'b1, 1'b1, 4'd7,  1'b1, 5,  S_FAULT, 0,  0, 1, 1};
        tbl[5]  = '{1'b1, 1'b1, 4'd7,  1'b0, 10, S_FAULT, 0,  0, 1, 1};
        tbl[6]  = '{1'b0, 1'b1, 4'd7,  1'b0, 5,  S_IDLE,  0,  0, 1, 0};
        tbl[7]  = '{1'b1, 1'b0, 4'd15, 1'b0, 90, S_RUN,   15, 1, 0, 0};
        tbl[8]  = '{1'b0, 1'b0, 4'd15, 1'b0, 90, S_IDLE,  0,  0, 0, 0};
        tbl[9]  = '{1'b1, 1'b1, 4'd2,  1'b0, 30, S_RUN,   2,  1, 1, 0};
        tbl[10] = '{1'b1, 1'b0, 4'd2,  1'b0, 50, S_RUN,   2,  1, 0, 0};

        // Reset state
        #10 nRstI = 1'b0;
        repeat (3) @(posedge clkI);
        #1;
        chkOut("reset", S_IDLE, 0, 0, 0, 0);
        chk("reset_inc", int'(m3freqINCo), 0);
        chk("reset_dec", int'(m3freqDECo), 0);
        nRstI = 1'b1;
        monOn = 1'b1;
        step(); step();

        // Start and ramp to 3: START seen, 3 INC pulses 4 cycles apart
        setCmd(1'b1, 1'b0, 4'd3, 1'b0);
        firstInc = -1; incN = 0; lastInc = 0; gapBad = 0;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (i == 2) chk("a_start_state", int'(stateO), S_START);
            if (m3freqINCo) begin
                if (firstInc < 0) firstInc = i;
                else if (i - lastInc != RAMP_DIV) gapBad++;
                lastInc = i;
                incN++;
            end
        end
        chk("a_first_inc_cycle", firstInc, 10);
        chk("a_inc_count", incN, 3);
        chk("a_inc_gap_errors", gapBad, 0);
        chkOut("a_end", S_RUN, 3, 1, 0, 0);

        // Direction flip at speed 3: decel, 8-cycle dwell, flip, re-ramp
        cmdDirI = 1'b1;
        incN = 0; decN = 0; startLow = 0; incBeforeFlip = 0; flipped = 1'b0;
        for (int i = 1; i <= 120; i++) begin
            step();
            if (m3invRotateO) flipped = 1'b1;
            if (m3freqDECo) decN++;
            if (m3freqINCo) begin
                incN++;
                if (!flipped) incBeforeFlip++;
            end
            if (!m3startO) startLow++;
        end
        chk("b_dec_count", decN, 3);
        chk("b_inc_count", incN, 3);
        chk("b_start_low_cycles", startLow, DWELL_CYC);
        chk("b_inc_before_flip", incBeforeFlip, 0);
        chkOut("b_end", S_RUN, 3, 1, 1, 0);

        // Ramp to 15, then down to 9 with exactly 6 DEC pulses
        cmdSpeedI = 4'd15;
        for (int i = 0; i < 120; i++) begin
            if (stateO == 3'(S_RUN) && speedNowO == 4'd15) break;
            step();
        end
        chkOut("d_at_15", S_RUN, 15, 1, 1, 0);
        cmdSpeedI = 4'd9;
        incN = 0; decN = 0;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (m3freqDECo) decN++;
            if (m3freqINCo) incN++;
        end
        chk("d_dec_count", decN, 6);
        chk("d_inc_count", incN, 0);
        chkOut("d_end", S_RUN, 9, 1, 1, 0);

        // Asynchronous reset at speed 5
        cmdSpeedI = 4'd5;
        for (int i = 0; i < 60; i++) begin
            if (stateO == 3'(S_RUN) && speedNowO == 4'd5) break;
            step();
        end
        chk("e_speed_before_reset", int'(speedNowO), 5);
        @(posedge clkI);
        #20 nRstI = 1'b0;
        #1;
        chkOut("e_async", S_IDLE, 0, 0, 0, 0);
        chk("e_async_inc", int'(m3freqINCo), 0);
        chk("e_async_dec", int'(m3freqDECo), 0);
        #100;
        cmdRunI = 1'b0;
        nRstI = 1'b1;
        #1;
        chk("e_release_state", int'(stateO), S_IDLE);
        step(); step(); step();

        // Fault landing on a ramp tick: no pulse, forced stop, latched release
        setCmd(1'b1, 1'b0, 4'd5, 1'b0);
        firstInc = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (m3freqINCo && firstInc < 0) begin
                firstInc = i;
                break;
            end
        end
        chk("c_first_inc_cycle", firstInc, 10);
        step(); step();
        faultI = 1'b1;
        step();
        chk("c_pre_fault_state", int'(stateO), S_RAMP);
        chk("c_pre_fault_speed", int'(speedNowO), 1);
        step();
        chk("c_fault_inc", int'(m3freqINCo), 0);
        chk("c_fault_dec", int'(m3freqDECo), 0);
        chkOut("c_fault", S_FAULT, 0, 0, 0, 1);
        faultI = 1'b0;
        repeat (6) step();
        chkOut("c_hold_run", S_FAULT, 0, 0, 0, 1);
        cmdRunI = 1'b0;
        step(); step();
        chkOut("c_release", S_IDLE, 0, 0, 0, 0);

        // Scenario table
        foreach (tbl[i]) begin
            setCmd(tbl[i].run, tbl[i].dir, tbl[i].spd, tbl[i].flt);
            repeat (tbl[i].hold) step();
            chkOut($sformatf("tbl%0d", i), tbl[i].eState, tbl[i].eSpd,
                   tbl[i].eStart, tbl[i].eInv, tbl[i].eFs);
        end

        // Random command streams, then a settled command checked against
        // the steady state it must lead to.
        lat = 1'b0;
        for (int k = 0; k < 30; k++) begin
            int nb;
            nb = int'($urandom_range(0, 3));
            for (int b = 0; b < nb; b++) begin
                rRun = ($urandom_range(0, 3) != 0);
                rDir = 1'($urandom_range(0, 1));
                rSpd = 4'($urandom_range(0, 15));
                rFlt = ($urandom_range(0, 7) == 0);
                setCmd(rRun, rDir, rSpd, rFlt);
                if (rFlt) lat = 1'b1;
                else if (!rRun) lat = 1'b0;
                repeat ($urandom_range(1, 20)) step();
            end
            rRun = ($urandom_range(0, 3) != 0);
            rDir = 1'($urandom_range(0, 1));
            rSpd = 4'($urandom_range(0, 15));
            rFlt = ($urandom_range(0, 9) == 0);
            setCmd(rRun, rDir, rSpd, rFlt);
            if (rFlt) lat = 1'b1;
            else if (!rRun) lat = 1'b0;
            repeat (180) step();
            if (lat)
                chkOut($sformatf("rnd%0d", k), S_FAULT, 0, 0, -1, 1);
            else if (rRun)
                chkOut($sformatf("rnd%0d", k), S_RUN,
                       (int'(rSpd) > SPD_MAX) ? SPD_MAX : int'(rSpd), 1, int'(rDir), 0);
            else
                chkOut($sformatf("rnd%0d", k), S_IDLE, 0, 0, -1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

    initial begin
        #(100 * 60000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
